// File: rtl/modulo_entrada_rolhas_operador.sv
// modulo_entrada_rolhas_operador: debounces the operator's refill buttons, accumulates a cork quantity
// and issues a range-checked one-cycle load of the new secondary-buffer total.
module modulo_entrada_rolhas_operador #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int MAX_BUFFER      = 99,
    parameter int CNT_W           = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_inc_n,
    input  logic             btn_confirm_n,
    input  logic [CNT_W-1:0] buffer_atual,
    output logic [CNT_W-1:0] qtd_pendente,
    output logic [CNT_W-1:0] total_carga,
    output logic             load_pulse,
    output logic             overflow,
    output logic [1:0]       estado
);
    typedef enum logic [1:0] {IDLE = 2'b00, ACUMULA = 2'b01, VALIDA = 2'b10, CARREGA = 2'b11} state_t;

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W:0]   MAX_SUM = MAX_BUFFER[CNT_W:0];
    localparam logic [CNT_W-1:0] MAX_Q   = MAX_BUFFER[CNT_W-1:0];

    // bit 0 = increment button, bit 1 = confirm button
    logic [1:0]           raw, sync1, sync2, level, press;
    logic [1:0][DB_W-1:0] db_cnt;
    logic [CNT_W:0]       sum;
    state_t               state;

    assign raw    = {btn_confirm_n, btn_inc_n};
    assign sum    = {1'b0, buffer_atual} + {1'b0, qtd_pendente};
    assign estado = state;

    // press fires on the same edge the debounced level falls, so it is a registered one-cycle event
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1  <= '1;
            sync2  <= '1;
            level  <= '1;
            press  <= '0;
            db_cnt <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int i = 0; i < 2; i++) begin
                press[i] <= 1'b0;
                if (sync2[i] == level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    level[i]  <= sync2[i];
                    db_cnt[i] <= '0;
                    press[i]  <= level[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            qtd_pendente <= '0;
            total_carga  <= '0;
            load_pulse   <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            load_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (press[0]) begin
                        qtd_pendente <= CNT_W'(1);
                        overflow     <= 1'b0;
                        state        <= ACUMULA;
                    end
                end
                ACUMULA: begin
                    // confirm has priority over a coincident increment
                    if (press[1]) state <= VALIDA;
                    else if (press[0] && qtd_pendente < MAX_Q) qtd_pendente <= qtd_pendente + CNT_W'(1);
                end
                VALIDA: begin
                    if (sum > MAX_SUM) begin
                        overflow     <= 1'b1;
                        qtd_pendente <= '0;
                        state        <= IDLE;
                    end else begin
                        total_carga <= sum[CNT_W-1:0];
                        load_pulse  <= 1'b1;
                        state       <= CARREGA;
                    end
                end
                CARREGA: begin
                    qtd_pendente <= '0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_modulo_entrada_rolhas_operador.sv
// tb_modulo_entrada_rolhas_operador: directed button sequences checked every cycle against a
// behavioural model, plus literal expectations for latencies, totals and limits.
module tb_modulo_entrada_rolhas_operador;
    localparam int DB   = 4;
    localparam int MAXB = 99;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_inc_n = 1'b1, btn_confirm_n = 1'b1;
    logic [6:0] buffer_atual = '0;
    logic [6:0] qtd_pendente, total_carga;
    logic       load_pulse, overflow;
    logic [1:0] estado;

    modulo_entrada_rolhas_operador #(.DEBOUNCE_CYCLES(DB), .MAX_BUFFER(MAXB), .CNT_W(7)) dut (
        .clk(clk), .reset(reset), .btn_inc_n(btn_inc_n), .btn_confirm_n(btn_confirm_n),
        .buffer_atual(buffer_atual), .qtd_pendente(qtd_pendente), .total_carga(total_carga),
        .load_pulse(load_pulse), .overflow(overflow), .estado(estado)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, pulses = 0, n, p0;
    bit chk_en = 0;

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // behavioural model: buttons reach the debouncer two samples late; a level flips after DB
    // consecutive disagreeing samples; a falling flip is an event seen by the controller next cycle
    int m_state, m_qtd, m_total, m_sum;
    int m_run[2];
    bit m_load, m_ovf, m_raw, m_smp;
    bit m_ev[2], m_lvl[2], m_s1[2], m_s2[2];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_state = 0; m_qtd = 0; m_total = 0; m_load = 0; m_ovf = 0;
            for (int i = 0; i < 2; i++) begin
                m_ev[i] = 0; m_lvl[i] = 1; m_s1[i] = 1; m_s2[i] = 1; m_run[i] = 0;
            end
        end else begin
            m_load = 0;
            if (m_state == 0) begin
                if (m_ev[0]) begin m_qtd = 1; m_ovf = 0; m_state = 1; end
            end else if (m_state == 1) begin
                if (m_ev[1]) m_state = 2;
                else if (m_ev[0]) m_qtd = (m_qtd + 1 > MAXB) ? MAXB : m_qtd + 1;
            end else if (m_state == 2) begin
                m_sum = int'(buffer_atual) + m_qtd;
                if (m_sum > MAXB) begin m_ovf = 1; m_qtd = 0; m_state = 0; end
                else begin m_total = m_sum; m_load = 1; m_state = 3; end
            end else begin
                m_qtd = 0; m_state = 0;
            end
            for (int i = 0; i < 2; i++) begin
                m_raw = (i == 0) ? btn_inc_n : btn_confirm_n;
                m_smp = m_s2[i];
                m_s2[i] = m_s1[i];
                m_s1[i] = m_raw;
                m_ev[i] = 0;
                if (m_smp == m_lvl[i]) m_run[i] = 0;
                else begin
                    m_run[i]++;
                    if (m_run[i] == DB) begin m_ev[i] = m_lvl[i]; m_lvl[i] = m_smp; m_run[i] = 0; end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("estado", int'(estado), m_state);
            chk("qtd_pendente", int'(qtd_pendente), m_qtd);
            chk("total_carga", int'(total_carga), m_total);
            chk("load_pulse", int'(load_pulse), int'(m_load));
            chk("overflow", int'(overflow), int'(m_ovf));
            if (load_pulse === 1'b1) pulses++;
        end
    end

    task automatic press(input bit i, input bit c);
        @(posedge clk); #2;
        btn_inc_n = !i; btn_confirm_n = !c;
        repeat (8) @(posedge clk);
        #2;
        btn_inc_n = 1'b1; btn_confirm_n = 1'b1;
        repeat (8) @(posedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk_en = 1;
        chk("rst_estado", int'(estado), 0);
        chk("rst_qtd", int'(qtd_pendente), 0);
        chk("rst_total", int'(total_carga), 0);
        chk("rst_load", int'(load_pulse), 0);
        chk("rst_ovf", int'(overflow), 0);
        reset = 1'b0;

        // three presses then confirm with 10 already in the buffer
        buffer_atual = 7'd10;
        repeat (3) press(1, 0);
        #2;
        chk("t1_qtd", int'(qtd_pendente), 3);
        @(posedge clk); #2;
        btn_confirm_n = 1'b0;
        n = 0;
        do begin @(posedge clk); #2; n++; end while (load_pulse !== 1'b1 && n < 20);
        chk("t1_confirm_to_load", n, 2 + DB + 2);
        chk("t1_total", int'(total_carga), 13);
        btn_confirm_n = 1'b1;
        repeat (8) @(posedge clk);
        #2;
        chk("t1_idle_estado", int'(estado), 0);
        chk("t1_idle_qtd", int'(qtd_pendente), 0);

        // bouncing increment, then a steady press
        @(posedge clk); #2;
        btn_inc_n = 1'b0; @(posedge clk); #2;
        btn_inc_n = 1'b1; @(posedge clk); #2;
        btn_inc_n = 1'b0; @(posedge clk); #2;
        btn_inc_n = 1'b1; @(posedge clk); #2;
        btn_inc_n = 1'b0;
        n = 0;
        do begin @(posedge clk); #2; n++; end while (qtd_pendente != 7'd1 && n < 20);
        chk("bounce_latency", n, 7);
        repeat (3) @(posedge clk);
        #2;
        btn_inc_n = 1'b1;
        repeat (8) @(posedge clk);
        #2;
        chk("bounce_single_event", int'(qtd_pendente), 1);
        buffer_atual = 7'd0;
        press(0, 1);

        // overflow rejection, then cleared by the next accepted increment
        buffer_atual = 7'd95;
        repeat (5) press(1, 0);
        p0 = pulses;
        press(0, 1);
        #2;
        chk("ovf_no_pulse", pulses - p0, 0);
        chk("ovf_flag", int'(overflow), 1);
        chk("ovf_qtd", int'(qtd_pendente), 0);
        chk("ovf_estado", int'(estado), 0);
        press(1, 0);
        #2;
        chk("ovf_cleared", int'(overflow), 0);
        buffer_atual = 7'd0;
        press(0, 1);

        // sum exactly at the limit is accepted
        buffer_atual = 7'd90;
        repeat (9) press(1, 0);
        p0 = pulses;
        press(0, 1);
        #2;
        chk("bound_pulse", pulses - p0, 1);
        chk("bound_total", int'(total_carga), 99);

        // buffer already beyond the limit rejects any confirm
        buffer_atual = 7'd120;
        press(1, 0);
        press(0, 1);
        #2;
        chk("big_buffer_ovf", int'(overflow), 1);

        // saturation of the pending quantity
        buffer_atual = 7'd0;
        repeat (120) press(1, 0);
        #2;
        chk("saturate_qtd", int'(qtd_pendente), 99);
        press(0, 1);
        #2;
        chk("saturate_total", int'(total_carga), 99);

        // coincident increment and confirm: confirm wins
        repeat (2) press(1, 0);
        press(1, 1);
        #2;
        chk("simul_total", int'(total_carga), 2);
        chk("simul_qtd", int'(qtd_pendente), 0);

        // reset while the load strobe is up
        press(1, 0);
        @(posedge clk); #2;
        btn_confirm_n = 1'b0;
        n = 0;
        do begin @(posedge clk); #2; n++; end while (estado != 2'b11 && n < 20);
        chk("carrega_reached", int'(estado), 3);
        reset = 1'b1;
        btn_confirm_n = 1'b1;
        #1;
        chk("rstc_load", int'(load_pulse), 0);
        chk("rstc_estado", int'(estado), 0);
        chk("rstc_total", int'(total_carga), 0);
        chk("rstc_qtd", int'(qtd_pendente), 0);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        p0 = pulses;
        repeat (20) @(posedge clk);
        #2;
        chk("rstc_no_pulse_after", pulses - p0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/modulo_entrada_rolhas_operador.md
Name: modulo_entrada_rolhas_operador

Overview:
Operator-side front end for manual cork (rolha) refills into the secondary cork buffer. Conditions two raw, active-low push-buttons (increment, confirm), accumulates a pending refill quantity, and range-checks it against the current secondary buffer count. On a valid confirm it issues a one-cycle load pulse with the new total. Feeds the secondary-buffer load path directly; replaces the ad-hoc debounce and pulse generation on that path.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable samples required to accept a button level change
MAX_BUFFER, 99, maximum allowed secondary-buffer total (display limit, 2 BCD digits)
CNT_W, 7, width of counts and totals

Ports:
clk  input  1  system clock (divided clock domain)
reset  input  1  asynchronous, active-high reset
btn_inc_n  input  1  raw increment button, active-low, asynchronous to clk
btn_confirm_n  input  1  raw confirm button, active-low, asynchronous to clk
buffer_atual  input  CNT_W  current secondary-buffer count, sampled in VALIDA
qtd_pendente  output  CNT_W  pending refill quantity being accumulated
total_carga  output  CNT_W  buffer_atual + qtd_pendente; valid while load_pulse=1
load_pulse  output  1  one-cycle strobe: load total_carga into the secondary buffer
overflow  output  1  last confirm rejected because the total would exceed MAX_BUFFER
estado  output  2  FSM state: 00 IDLE, 01 ACUMULA, 10 VALIDA, 11 CARREGA

Behaviour:
- Reset (async, active-high): state IDLE; qtd_pendente=0, total_carga=0, load_pulse=0, overflow=0; synchronisers =1 (released); debounce counters=0; debounced levels=1.
- Input conditioning, per button: 2-flop synchroniser; the debounced level changes only after DEBOUNCE_CYCLES consecutive samples differ from it; the counter clears on any sample equal to it. A press event is a one-cycle pulse on a debounced 1->0 transition. Raw press to event latency = 2 + DEBOUNCE_CYCLES cycles. Glitches shorter than DEBOUNCE_CYCLES cycles produce no event.
- Holding a button produces exactly one event; a new event needs a debounced release first.
- IDLE: inc event -> qtd_pendente=1, overflow cleared, go ACUMULA. Confirm event ignored.
- ACUMULA: inc event -> qtd_pendente+1, saturating at MAX_BUFFER. Confirm event -> VALIDA.
- VALIDA (exactly one cycle): compute sum = buffer_atual + qtd_pendente in CNT_W+1 bits. If sum > MAX_BUFFER: overflow=1, qtd_pendente=0, go IDLE. Else total_carga=sum[CNT_W-1:0], go CARREGA.
- CARREGA (exactly one cycle): load_pulse=1, total_carga stable; next cycle load_pulse=0, qtd_pendente=0, go IDLE. total_carga holds its last value until the next load.
- Confirm event to load_pulse latency: 2 cycles.
- Events arriving in VALIDA or CARREGA are dropped, not queued.
- Simultaneous inc and confirm events in ACUMULA: confirm wins; the increment is dropped.
- sum == MAX_BUFFER is accepted. buffer_atual already > MAX_BUFFER rejects any confirm with overflow=1.
- overflow stays set until the next accepted inc event from IDLE or a reset.
- Reset asserted mid-operation, including during CARREGA: immediate return to reset values; no load_pulse is emitted after reset.

Test Plan:
- Reset with DEBOUNCE_CYCLES=4: 3 inc presses, then confirm, buffer_atual=10 -> qtd_pendente=3; load_pulse high 1 cycle exactly 2 cycles after the confirm event; total_carga=13; back to IDLE with qtd_pendente=0.
- Bounce: btn_inc_n toggles every cycle for 3 cycles, then is held low for 10 cycles -> exactly one inc event, issued 6 cycles after the stable-low start; qtd_pendente=1.
- Overflow: buffer_atual=95, 5 presses, confirm -> no load_pulse; overflow=1; qtd_pendente=0; estado=IDLE. Next inc press -> overflow=0.
- Boundary: buffer_atual=90, 9 presses, confirm -> load_pulse, total_carga=99. Pressing 120 times from IDLE -> qtd_pendente saturates at 99.
- Simultaneous inc and confirm events in ACUMULA with qtd_pendente=2, buffer_atual=0 -> total_carga=2, not 3.
- Reset asserted in the CARREGA cycle -> load_pulse=0 immediately; all outputs at reset values; no pulse after reset release.
